// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encoding, default sizing and width helper for the TDM select-scan receiver.
// Optional feature macro used by this slice: TDM_MAJORITY_EN (2-of-3 majority sampling of z_in).
package tdm_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DWELL = 4;
    localparam int DEF_SEL_W = clog2_min1(DEF_WIDTH);

endpackage

// File: rtl/tdm_dwell_cnt.sv
// tdm_dwell_cnt: dwell counter 0..DWELL-1 with last-cycle flag and majority sample strobes.
// With TDM_MAJORITY_EN defined it also provides strobes at dwell DWELL-3 and DWELL-2.
module tdm_dwell_cnt
    import tdm_pkg::*;
#(
    parameter int DWELL = DEF_DWELL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic last
`ifdef TDM_MAJORITY_EN
    ,
    output logic early,
    output logic mid
`endif
);

    localparam int CW = clog2_min1(DWELL);

    logic [CW-1:0] cnt;

    assign last = cnt == CW'(DWELL - 1);
`ifdef TDM_MAJORITY_EN
    assign early = cnt == CW'(DWELL - 3);
    assign mid   = cnt == CW'(DWELL - 2);
`endif

    // Count while scanning, wrap after the last dwell cycle, hold at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= (!run || last) ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx: scans an external WIDTH:1 mux via sel, samples z_in per channel and emits parallel frames.
// Define TDM_MAJORITY_EN to take a 2-of-3 majority of the last three dwell samples instead of one sample.
module tdm_demux_rx
    import tdm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W,
    parameter int DWELL = DEF_DWELL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             z_in,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    output logic             busy
);

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] shadow;
    logic             run;
    logic             last;
    logic             sample;

    // Counter only advances in SCAN with en held; dropping en clears it along with the abort.
    assign run  = (state == ST_SCAN) && en;
    assign busy = state != ST_IDLE;

`ifdef TDM_MAJORITY_EN
    logic early;
    logic mid;
    logic s_a;
    logic s_b;

    tdm_dwell_cnt #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .last  (last),
        .early (early),
        .mid   (mid)
    );

    // Capture the two earlier dwell samples; the third comes live from z_in on the last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_a <= 1'b0;
            s_b <= 1'b0;
        end else begin
            if (run && early) s_a <= z_in;
            if (run && mid)   s_b <= z_in;
        end
    end

    assign sample = (s_a & s_b) | (s_a & z_in) | (s_b & z_in);
`else
    tdm_dwell_cnt #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .last  (last)
    );

    assign sample = z_in;
`endif

    // Frame FSM: step sel through all channels, publish the shadow word in the one-cycle DONE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sel     <= '0;
            shadow  <= '0;
            d_out   <= '0;
            d_valid <= 1'b0;
        end else begin
            d_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sel <= '0;
                    if (en) state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (!en) begin
                        state <= ST_IDLE;
                        sel   <= '0;
                    end else if (last) begin
                        shadow[sel] <= sample;
                        if (sel == SEL_LAST) begin
                            state <= ST_DONE;
                            sel   <= '0;
                        end else begin
                            sel <= sel + SEL_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    d_out   <= shadow;
                    d_valid <= 1'b1;
                    sel     <= '0;
                    state   <= en ? ST_SCAN : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    sel   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb_tdm_demux_rx: scoreboard bench for tdm_demux_rx (WIDTH=4, DWELL=4) with a behavioural 4:1 mux on z_in.
module tb_tdm_demux_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       glitch = 1'b0;
    logic [3:0] d = 4'd0;
    logic       z_in;
    logic [1:0] sel;
    logic [3:0] d_out;
    logic       d_valid;
    logic       busy;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;
    int         cycles;

    // External mux model: channel i drives bit i of d; glitch inverts the mux output.
    assign z_in = d[sel] ^ glitch;

    tdm_demux_rx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .z_in    (z_in),
        .sel     (sel),
        .d_out   (d_out),
        .d_valid (d_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every d_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n && d_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: d_out=%b, expected no pulse", d_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("frame_d_out", int'(d_out), int'(mon_exp));
            end
        end
    end

    // One full frame from IDLE, with an optional one-edge glitch at edge g (edge 0 samples en).
    task automatic run_frame(input logic [3:0] v, input int g, input logic [3:0] ex);
        d = v;
        exp_q.push_back(ex);
        en = 1'b1;
        for (int e = 0; e < 17; e++) begin
            glitch = (e == g);
            @(posedge clk);
            @(negedge clk);
        end
        glitch = 1'b0;
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_sel", int'(sel), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with en high: everything stays at reset values.
        en = 1'b1;
        d = 4'b1010;
        repeat (3) @(negedge clk);
        check("rst_sel", int'(sel), 0);
        check("rst_d_out", int'(d_out), 0);
        check("rst_d_valid", int'(d_valid), 0);
        check("rst_busy", int'(busy), 0);

        // Continuous frames of 1010: three frames, the last closed by dropping en in DONE.
        repeat (3) exp_q.push_back(4'b1010);
        rst_n = 1'b1;
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!d_valid && cycles < 40);
        // Edge that samples en, plus 16 scan edges and the DONE edge.
        check("first_valid_edges", cycles, 1 + 4 * 4 + 1);
        for (int k = 0; k < 34; k++) begin
            if (k > 0) @(negedge clk);
            check("cont_sel", int'(sel), (k % 17 < 16) ? (k % 17) / 4 : 0);
            check("cont_valid", int'(d_valid), (k % 17 == 0) ? 1 : 0);
            if (k == 5) check("cont_busy", int'(busy), 1);
        end
        en = 1'b0;
        @(negedge clk);
        check("done_exit_valid", int'(d_valid), 1);
        @(negedge clk);
        check("done_exit_idle", int'(busy), 0);

        // Loopback sweep over all 16 words.
        for (int i = 0; i < 16; i++) run_frame(4'(i), -1, 4'(i));

        // Abort during sel=2 after a completed 1001 frame.
        run_frame(4'b1001, -1, 4'b1001);
        d = 4'b0110;
        en = 1'b1;
        for (int e = 0; e < 9; e++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_sel_at_drop", int'(sel), 2);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_sel", int'(sel), 0);
        repeat (20) @(negedge clk);
        check("abort_d_out_held", int'(d_out), 4'b1001);
        run_frame(4'b0110, -1, 4'b0110);
        check("restart_d_out", int'(d_out), 4'b0110);

        // Asynchronous reset at sel=3: outputs clear before the next clock edge.
        d = 4'b1111;
        en = 1'b1;
        for (int e = 0; e < 13; e++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("midrst_sel_before", int'(sel), 3);
        check("midrst_busy_before", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_sel", int'(sel), 0);
        check("midrst_d_out", int'(d_out), 0);
        check("midrst_d_valid", int'(d_valid), 0);
        check("midrst_busy", int'(busy), 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Glitch on channel 0 of d=0001.
`ifdef TDM_MAJORITY_EN
        // Edge 2 is the dwell-1 edge of channel 0; majority outvotes it.
        run_frame(4'b0001, 2, 4'b0001);
`else
        // Edge 4 is the dwell-3 edge of channel 0; the single sample takes the glitch.
        run_frame(4'b0001, 4, 4'b0000);
`endif

        repeat (4) @(negedge clk);
        check("pending_frames", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
- Receive end of the 4:1 mux select-scan link.
- Drives the select lines of an external WIDTH:1 multiplexer, dwells on each select, and samples the mux output bit.
- Reassembles the scanned bits into a parallel word and presents it with a one-cycle valid pulse.
- Sits between the mux-based serial source and downstream parallel logic.

Parameters:
- WIDTH, 4, number of mux data inputs (channels) per frame; must be ≥2.
- SEL_W, 2, select width; equals ceil(log2(WIDTH)).
- DWELL, 4, clock cycles held on each select value; must be ≥1, and ≥3 when TDM_MAJORITY_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  scan enable; high = run frames continuously.
- z_in  input  1  mux output bit for the current sel.
- sel  output  SEL_W  select driven to the external mux.
- d_out  output  WIDTH  last completed frame, bit i = channel i.
- d_valid  output  1  one-cycle pulse when d_out updates.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, sel=0, dwell counter=0, shadow=0, d_out=0, d_valid=0, busy=0.
- States:
  - IDLE: sel=0, busy=0. When en=1 at a clock edge, go to SCAN with dwell=0 and sel=0.
  - SCAN: busy=1. dwell counts 0..DWELL-1.
    - On the edge where dwell==DWELL-1, sample shadow[sel] <= z_in.
    - If sel<WIDTH-1: sel <= sel+1, dwell <= 0.
    - If sel==WIDTH-1: go to DONE.
  - DONE: lasts one cycle. d_out <= shadow with all WIDTH bits (including the final sample) and d_valid=1 in this cycle.
    - If en=1: next state SCAN, sel=0, dwell=0 (back-to-back frames).
    - Else: go to IDLE.
- z_in is assumed combinational from sel; it is sampled at the last dwell cycle so the mux output has settled for DWELL-1 cycles.
- Frame period: WIDTH*DWELL+1 cycles. First d_valid occurs WIDTH*DWELL+1 cycles after en is sampled high.
- d_valid is registered and high for exactly one cycle per frame. d_out holds its value between frames.
- en deasserted in SCAN: abort at the next edge and go to IDLE. sel returns to 0, the partial shadow is discarded (no d_out update, no d_valid), and d_out keeps the last complete frame.
- en deasserted in DONE: the frame completes normally (d_valid still fires), then IDLE.
- Asynchronous reset mid-frame: immediate return to reset values; no d_valid.
- sel never exceeds WIDTH-1. Wrap from WIDTH-1 back to 0 happens only via DONE.

Optional Feature:
- Macro TDM_MAJORITY_EN.
- Defined: z_in is sampled at dwell DWELL-3, DWELL-2 and DWELL-1. shadow[sel] takes the 2-of-3 majority, which rejects single-cycle glitches on z_in.
- Not defined: a single sample at dwell DWELL-1.
- Timing is identical in both cases.

Decomposition:
- Package tdm_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SCAN=2'd1, ST_DONE=2'd2;
  - the default WIDTH/SEL_W/DWELL values;
  - a clog2-style helper function for SEL_W.
- One natural sub-module, tdm_dwell_cnt: counts 0..DWELL-1, clears on load, and outputs a last-cycle flag plus the majority sample strobes.

Test Plan:
- Reset: hold rst_n=0 with en=1 → sel=0, d_out=0, d_valid=0, busy=0. Release → first d_valid at cycle 17 (WIDTH=4, DWELL=4).
- Loopback sweep: a behavioural 4:1 mux feeds z_in from d=0..15, with d changed only in IDLE. Each frame gives d_out==d with a single d_valid pulse.
- Continuous: en held high with d=4'b1010 → d_valid every 17 cycles and d_out=4'b1010 each frame. sel sequence is 0,1,2,3 with 4 cycles each, then 1 idle-select DONE cycle.
- Abort: drop en during sel=2 with d=4'b0110 after a prior frame of 4'b1001 → IDLE next edge, no d_valid, d_out stays 4'b1001. A later restart yields 4'b0110.
- Mid-frame reset: assert rst_n low at sel=3 → all outputs zero asynchronously, before the next clock edge.
- With TDM_MAJORITY_EN: inject a one-cycle inverted glitch on z_in at dwell 1 of channel 0 (d=4'b0001) → d_out=4'b0001. Without the macro, a glitch at dwell 3 → d_out=4'b0000.
